// File: rtl/sfu_pkg.sv
// Shared fp16 types, constants and reduction FSM state encoding.
// No logic; imported by the SFU reduction datapath and its adder.
// Constants are the canonical encodings used for reset and special results.
package sfu_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_POS_ZERO = 16'h0000;
  localparam fp16_t FP16_POS_INF  = 16'h7C00;
  localparam fp16_t FP16_ONE      = 16'h3C00;
  localparam fp16_t FP16_QNAN     = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acc_state_e;

endpackage

// File: rtl/new_fp16_add.sv
// Two-operand fp16 adder, IEEE round-to-nearest-even, subnormals supported.
// Latency: purely combinational.
// Backpressure: none; result follows the operands in the same cycle.
module new_fp16_add
  import sfu_pkg::*;
(
  input  logic [31:0] operands_i,
  output logic [15:0] result_o
);

  fp16_t       a, b, x, y;
  logic [4:0]  ex, ey;
  logic [5:0]  d;
  logic [13:0] mx, my, my_sh;
  logic [14:0] s;
  logic [6:0]  e;
  logic [11:0] mr;
  logic        sticky, up, x_nan, y_nan, x_inf, y_inf;

  assign a = operands_i[31:16];
  assign b = operands_i[15:0];

  // Order operands so x has the larger magnitude; alignment then only shifts y
  always_comb begin
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
  end

  // Align, add/subtract with guard/round/sticky, normalise, round to nearest even
  always_comb begin
    x_nan  = (&x[14:10]) && (|x[9:0]);
    y_nan  = (&y[14:10]) && (|y[9:0]);
    x_inf  = (&x[14:10]) && !(|x[9:0]);
    y_inf  = (&y[14:10]) && !(|y[9:0]);
    ex     = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey     = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    mx     = {(x[14:10] != 5'd0), x[9:0], 3'b000};
    my     = {(y[14:10] != 5'd0), y[9:0], 3'b000};
    d      = {1'b0, ex} - {1'b0, ey};
    if (d >= 6'd14) begin
      my_sh  = '0;
      sticky = |my;
    end else begin
      my_sh  = my >> d;
      sticky = |(my & ~(14'h3FFF << d));
    end
    my_sh[0] = my_sh[0] | sticky;

    if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my_sh};
    else                s = {1'b0, mx} - {1'b0, my_sh};

    e = {2'b00, ex};
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 7'd1;
    end else begin
      // Stop at e==1 so tiny results come out as subnormals
      for (int i = 0; i < 13; i++) begin
        if (!s[13] && (e > 7'd1)) begin
          s = {s[13:0], 1'b0};
          e = e - 7'd1;
        end
      end
    end

    up = s[2] & (s[1] | s[0] | s[3]);
    mr = {1'b0, s[13:3]} + {11'd0, up};
    if (mr[11]) begin
      mr = {1'b0, mr[11:1]};
      e  = e + 7'd1;
    end

    if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15])))
      result_o = FP16_QNAN;
    else if (x_inf)
      result_o = FP16_POS_INF | {x[15], 15'd0};
    else if (s == 15'd0)
      result_o = {x[15] & y[15], 15'd0};
    else if (e >= 7'd31)
      result_o = FP16_POS_INF | {x[15], 15'd0};
    else
      result_o = {x[15], (mr[10] ? e[4:0] : 5'd0), mr[9:0]};
  end

endmodule

// File: rtl/acc_sum_reduce.sv
// Sequential fp16 sum of data_cnt array elements, one element per clock.
// Latency: data_cnt+1 cycles from accepted start to done.
// Backpressure: start is ignored while busy; array must stay stable while busy.
module acc_sum_reduce
  import sfu_pkg::*;
#(
  parameter int data_width = 16,
  parameter int data_cnt   = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [data_width*data_cnt-1:0]   array,
  output logic                             busy,
  output logic                             done,
  output logic [data_width-1:0]            sum
);

  // One spare idx bit so a power-of-two count never wraps to zero
  localparam int IDX_W = $clog2(data_cnt) + 1;
  localparam int SEL_W = (data_cnt > 1) ? $clog2(data_cnt) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_cnt - 1);

  acc_state_e      state, state_nxt;
  logic [IDX_W-1:0] idx;
  fp16_t           acc, operand, add_res;
  fp16_t           elem [data_cnt];

  for (genvar g = 0; g < data_cnt; g++) begin : g_elem
    assign elem[g] = array[g*data_width +: data_width];
  end

  // Single element mux feeding the shared adder
  assign operand = elem[idx[SEL_W-1:0]];

  new_fp16_add u_add (
    .operands_i ({acc, operand}),
    .result_o   (add_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: start only matters outside RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pure decodes of the registered state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Accumulator, element index and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      acc <= FP16_POS_ZERO;
      sum <= FP16_POS_ZERO;
    end else begin
      case (state)
        RUN: begin
          acc <= add_res;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) sum <= add_res;
        end
        IDLE, DONE: begin
          if (start) begin
            idx <= '0;
            acc <= FP16_POS_ZERO;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/acc_sum_reduce.md
Name: acc_sum_reduce

Overview:
- Sequential fp16 reduction engine. Reads a parallel array of data_cnt fp16 values one element per cycle and accumulates them into a single fp16 sum.
- Consumes the squared-element array produced by the SFU squaring stage. Sum-of-squares feeds the norm/variance path.
- Uses one shared combinational fp16 adder and a start/busy/done handshake, so the upstream producer can hand over a filled array.

Parameters:
- data_width, 16, element width in bits (fp16 only; other values unsupported).
- data_cnt, 64, number of array elements reduced per operation; legal range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request a new reduction; sampled on rising clk edge.
- array  in  data_width x data_cnt  fp16 operands; must be held stable while busy=1.
- busy  out  1  high while elements are being accumulated.
- done  out  1  high from reduction completion until the next accepted start or reset.
- sum  out  data_width  fp16 accumulated result; valid when done=1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, idx=0, acc=16'h0000, busy=0, done=0, sum=16'h0000. Reset mid-RUN aborts with no partial result retained.
- idx width: $clog2(data_cnt)+1 bits, so no wrap at data_cnt=2^k.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → RUN with idx=0, acc=+0 (16'h0000). start=0 → stay in IDLE.
- RUN: each edge performs acc <= fp16_add(acc, array[idx]) and idx <= idx+1.
  - The edge that consumes idx==data_cnt-1 moves to DONE and registers sum <= the final adder result.
  - start is ignored in RUN (no restart, no queueing).
- DONE: done=1, sum is held. start=1 → RUN (same as from IDLE), done drops on that edge. Otherwise stay in DONE.
- Outputs: busy = (state==RUN); done = (state==DONE). Both are registered-state decodes with no combinational path from start.
- Latency: start high in cycle 0 → busy in cycles 1..data_cnt → done=1 first visible in cycle data_cnt+1. Back-to-back start in the first DONE cycle gives a throughput of one reduction per data_cnt+1 cycles.
- data_cnt=1: a single RUN cycle; sum = 0 + array[0].
- Arithmetic:
  - Strict in-order left fold: ((0+a0)+a1)+…
  - Adder rounding and specials (inf, NaN, signed zero) are defined by the adder sub-module. No extra saturation.
  - -0 inputs on a +0 accumulator give whatever the adder produces; the bench treats 0000 and 8000 as equal only in the zero-sum test.
- Only array[idx] is read each cycle, through a single data_cnt:1 mux into the adder operand.

Decomposition:
- Shared package sfu_pkg:
  - typedef fp16_t (logic [15:0]).
  - constants FP16_POS_ZERO=16'h0000, FP16_POS_INF=16'h7C00, FP16_ONE=16'h3C00.
  - enum acc_state_e {IDLE, RUN, DONE}.
- Sub-module: new_fp16_add, a combinational two-operand fp16 adder with ports operands_i [31:0] = {a,b} and result_o [15:0]. It mirrors the existing fp16 multiplier interface and is instantiated once. Unit test it separately before integration.

Test Plan:
- All 64 elements = 16'h3C00 (1.0), pulse start → busy for 64 cycles, done in cycle 65, sum=16'h5400 (64.0).
- All elements = 16'h3800 (0.5), then a second start in the first DONE cycle → second sum=16'h5000 (32.0), done low for exactly 64 cycles between the two results.
- Elements alternating 16'h3C00 / 16'hBC00 (+1/-1) → sum is a zero encoding (16'h0000 or 16'h8000), done asserted.
- Element 10 = 16'h7C00, all others 16'h4000 → sum=16'h7C00.
- Drive rst=0 asynchronously mid-RUN (idx=30), release, start with all 16'h4400 (4.0) → busy/done/sum are 0 during reset, and the new result is sum=16'h5C00 (256.0) with no residue from the aborted run.
- start pulsed while busy, and data_cnt=1 build with array[0]=16'h4248 → the mid-run start is ignored; the data_cnt=1 build gives done in cycle 2 with sum=16'h4248.
